// File: rtl/lsu_dmem_if_if.sv
// Request/response channel between the core memory stage and the LSU, plus the
// LSU's connection to RAM port b. Signal names are as seen from the LSU.
// slave modport: the LSU. master modport: core and RAM side.
`timescale 1ns/1ps
interface lsu_dmem_if_if #(
  parameter int MEM_ADDR_WIDTH = 12
) ();
  logic                      i_req_valid;
  logic                      o_req_ready;
  logic                      i_req_we;
  logic [31:0]               i_req_addr;
  logic [1:0]                i_req_size;
  logic                      i_req_unsigned;
  logic [31:0]               i_req_wdata;
  logic                      o_rsp_valid;
  logic                      i_rsp_ready;
  logic [31:0]               o_rsp_rdata;
  logic                      o_rsp_err;
  logic [MEM_ADDR_WIDTH-1:0] o_mem_addr;
  logic                      o_mem_we;
  logic [1:0]                o_mem_size;
  logic [31:0]               o_mem_din;
  logic [31:0]               i_mem_dout;

  modport slave (
    input  i_req_valid, i_req_we, i_req_addr, i_req_size, i_req_unsigned,
           i_req_wdata, i_rsp_ready, i_mem_dout,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
           o_mem_addr, o_mem_we, o_mem_size, o_mem_din
  );

  modport master (
    output i_req_valid, i_req_we, i_req_addr, i_req_size, i_req_unsigned,
           i_req_wdata, i_rsp_ready, i_mem_dout,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
           o_mem_addr, o_mem_we, o_mem_size, o_mem_din
  );
endinterface

// File: rtl/lsu_dmem_if.sv
// Load/store unit in front of RAM port b. One transaction in flight; stores and
// faults respond the cycle after accept, loads two cycles after accept (RAM has a
// registered read). Load data is sign/zero-extended per the request.
// Optional build macro MISALIGN_TRAP_EN: misaligned half/word accesses fault
// instead of being passed to the RAM.
`timescale 1ns/1ps
module lsu_dmem_if #(
  parameter int MEM_DEPTH      = 4096,
  parameter int MEM_ADDR_WIDTH = 12
) (
  input logic            i_clk,
  input logic            i_rst_n,
  lsu_dmem_if_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RDWAIT = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic                      req_ready;
  logic                      accept;
  logic                      fault;
  logic                      accept_to_resp;

  logic [MEM_ADDR_WIDTH-1:0] req_addr_p0;
  logic [1:0]                req_size_p0;
  logic [31:0]               req_din_p0;
  logic                      req_uns_p0;

  logic [31:0]               rsp_rdata_p1;
  logic                      rsp_err_p1;

  // Address of the last byte touched; 33 bits so requests near 0xFFFFFFFF
  // cannot wrap back into range.
  function automatic logic [32:0] last_byte(input logic [31:0] a, input logic [1:0] sz);
    logic [1:0] off;
    case (sz)
      2'b00:   off = 2'd0;
      2'b01:   off = 2'd1;
      default: off = 2'd3;
    endcase
    return {1'b0, a} + {31'd0, off};
  endfunction

  // Extend raw RAM data to 32 bits according to the access size.
  function automatic logic [31:0] load_ext(input logic [31:0] d, input logic [1:0] sz,
                                           input logic uns);
    logic sgn;
    case (sz)
      2'b00: begin
        sgn = ~uns & d[7];
        return {{24{sgn}}, d[7:0]};
      end
      2'b01: begin
        sgn = ~uns & d[15];
        return {{16{sgn}}, d[15:0]};
      end
      default: return d;
    endcase
  endfunction

  // Access fault classification of the incoming request.
  always_comb begin
    fault = (bus.i_req_size == 2'b11) |
            (last_byte(bus.i_req_addr, bus.i_req_size) >= 33'(MEM_DEPTH));
`ifdef MISALIGN_TRAP_EN
    if ((bus.i_req_size == 2'b01) && bus.i_req_addr[0])
      fault = 1'b1;
    if ((bus.i_req_size == 2'b10) && (bus.i_req_addr[1:0] != 2'b00))
      fault = 1'b1;
`endif
  end

  assign req_ready      = (state_q == IDLE) | ((state_q == RESP) & bus.i_rsp_ready);
  assign accept         = bus.i_req_valid & req_ready;
  assign accept_to_resp = fault | bus.i_req_we;

  assign bus.o_req_ready = req_ready;
  assign bus.o_mem_we    = accept & bus.i_req_we & ~fault & i_rst_n;
  assign bus.o_mem_addr  = accept ? bus.i_req_addr[MEM_ADDR_WIDTH-1:0] : req_addr_p0;
  assign bus.o_mem_size  = accept ? bus.i_req_size  : req_size_p0;
  assign bus.o_mem_din   = accept ? bus.i_req_wdata : req_din_p0;

  assign bus.o_rsp_valid = (state_q == RESP);
  assign bus.o_rsp_rdata = rsp_rdata_p1;
  assign bus.o_rsp_err   = rsp_err_p1;

  // Next-state selection; a handoff cycle in RESP can start the next request.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept)
          state_d = accept_to_resp ? RESP : RDWAIT;
      end
      RDWAIT: state_d = RESP;
      RESP: begin
        if (bus.i_rsp_ready)
          state_d = accept ? (accept_to_resp ? RESP : RDWAIT) : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // --- stage p0: request captured at accept, keeps port b stable afterwards ---
  always_ff @(posedge i_clk) begin
    if (accept) begin
      req_addr_p0 <= bus.i_req_addr[MEM_ADDR_WIDTH-1:0];
      req_size_p0 <= bus.i_req_size;
      req_din_p0  <= bus.i_req_wdata;
      req_uns_p0  <= bus.i_req_unsigned;
    end
  end

  // --- stage p1: response data, held until the core takes it ---
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rsp_rdata_p1 <= 32'd0;
      rsp_err_p1   <= 1'b0;
    end else if (accept) begin
      rsp_rdata_p1 <= 32'd0;
      rsp_err_p1   <= fault;
    end else if (state_q == RDWAIT) begin
      rsp_rdata_p1 <= load_ext(bus.i_mem_dout, req_size_p0, req_uns_p0);
      rsp_err_p1   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lsu_dmem_if.sv
// Randomized bench for lsu_dmem_if with a byte-array reference model and a
// simple registered-read RAM on port b.
`timescale 1ns/1ps
module tb_lsu_dmem_if;

  localparam int DEPTH = 4096;

  logic clk;
  logic rst_n;
  logic ram_clr;

  lsu_dmem_if_if #(.MEM_ADDR_WIDTH(12)) bus ();

  lsu_dmem_if #(.MEM_DEPTH(DEPTH), .MEM_ADDR_WIDTH(12)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM port b: byte lanes written at the edge, 4 bytes read registered.
  logic [7:0] ram [0:DEPTH-1];
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= 8'h00;
    end else if (bus.o_mem_we) begin
      for (int i = 0; i < nbytes(bus.o_mem_size); i++)
        ram[(int'(bus.o_mem_addr) + i) % DEPTH] <= bus.o_mem_din[8*i +: 8];
    end
    bus.i_mem_dout <= {ram[(int'(bus.o_mem_addr) + 3) % DEPTH],
                       ram[(int'(bus.o_mem_addr) + 2) % DEPTH],
                       ram[(int'(bus.o_mem_addr) + 1) % DEPTH],
                       ram[int'(bus.o_mem_addr)]};
  end

  // Reference memory contents.
  logic [7:0] ref_mem [0:DEPTH-1];

  int n_vec = 0;
  int n_mis = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit exp_fault(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'd3) return 1'b1;
    if (64'(a) + 64'(nbytes(sz)) > 64'(DEPTH)) return 1'b1;
`ifdef MISALIGN_TRAP_EN
    if (sz == 2'd1 && (a % 2) != 0) return 1'b1;
    if (sz == 2'd2 && (a % 4) != 0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [1:0] sz,
                                           input logic uns);
    logic [63:0] v;
    int n;
    n = nbytes(sz);
    v = 64'd0;
    for (int i = 0; i < n; i++)
      v = v + (64'(ref_mem[(int'(a) + i) % DEPTH]) << (8 * i));
    if (!uns && v[8*n-1])
      v = v - (64'd1 << (8 * n));
    return v[31:0];
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    for (int i = 0; i < nbytes(sz); i++)
      ref_mem[(int'(a) + i) % DEPTH] = d[8*i +: 8];
  endtask

  task automatic drive_req(input logic we, input logic [31:0] a, input logic [1:0] sz,
                           input logic uns, input logic [31:0] d);
    bus.i_req_valid    = 1'b1;
    bus.i_req_we       = we;
    bus.i_req_addr     = a;
    bus.i_req_size     = sz;
    bus.i_req_unsigned = uns;
    bus.i_req_wdata    = d;
  endtask

  // One complete transaction from an idle LSU, response held off for `hold` cycles.
  task automatic do_txn(input logic we, input logic [31:0] a, input logic [1:0] sz,
                        input logic uns, input logic [31:0] d, input int hold);
    bit f, ew;
    logic [31:0] er;
    int lat;
    f  = exp_fault(a, sz);
    ew = we && !f;
    er = (!f && !we) ? exp_load(a, sz, uns) : 32'd0;
    @(negedge clk);
    drive_req(we, a, sz, uns, d);
    bus.i_rsp_ready = 1'b0;
    #1;
    check_val("req_ready_idle", 32'(bus.o_req_ready), 32'd1);
    check_val("mem_we_accept", 32'(bus.o_mem_we), 32'(ew));
    if (ew) begin
      check_val("mem_addr", 32'(bus.o_mem_addr), a % DEPTH);
      check_val("mem_size", 32'(bus.o_mem_size), 32'(sz));
      check_val("mem_din", bus.o_mem_din, d);
    end
    @(posedge clk);
    if (ew) ref_store(a, sz, d);
    @(negedge clk);
    bus.i_req_valid = 1'b0;
    #1;
    lat = 1;
    while (!bus.o_rsp_valid && lat < 8) begin
      @(negedge clk);
      #1;
      lat++;
    end
    check_val("rsp_latency", 32'(lat), (f || we) ? 32'd1 : 32'd2);
    check_val("rsp_err", 32'(bus.o_rsp_err), 32'(f));
    check_val("rsp_rdata", bus.o_rsp_rdata, er);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      #1;
      check_val("hold_valid", 32'(bus.o_rsp_valid), 32'd1);
      check_val("hold_rdata", bus.o_rsp_rdata, er);
      check_val("hold_ready", 32'(bus.o_req_ready), 32'd0);
      check_val("hold_mem_we", 32'(bus.o_mem_we), 32'd0);
    end
    bus.i_rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.i_rsp_ready = 1'b0;
    #1;
    check_val("rsp_drop", 32'(bus.o_rsp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [31:0] er, a;
    logic [1:0]  sz;
    int r;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
    rst_n   = 1'b0;
    ram_clr = 1'b1;
    bus.i_req_valid = 1'b0;
    bus.i_req_we = 1'b0;
    bus.i_req_addr = 32'd0;
    bus.i_req_size = 2'd0;
    bus.i_req_unsigned = 1'b0;
    bus.i_req_wdata = 32'd0;
    bus.i_rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_rsp_valid", 32'(bus.o_rsp_valid), 32'd0);
    check_val("rst_rsp_err", 32'(bus.o_rsp_err), 32'd0);
    check_val("rst_rsp_rdata", bus.o_rsp_rdata, 32'd0);
    check_val("rst_mem_we", 32'(bus.o_mem_we), 32'd0);
    ram_clr = 1'b0;
    rst_n   = 1'b1;

    // Directed cases
    do_txn(1'b1, 32'h100, 2'd2, 1'b0, 32'hDEADBEEF, 0);
    do_txn(1'b0, 32'h100, 2'd2, 1'b0, 32'h0, 1);
    do_txn(1'b0, 32'h103, 2'd0, 1'b0, 32'h0, 0);
    do_txn(1'b0, 32'h103, 2'd0, 1'b1, 32'h0, 0);
    do_txn(1'b0, 32'h102, 2'd1, 1'b0, 32'h0, 0);
    do_txn(1'b0, 32'hFFD, 2'd2, 1'b0, 32'h0, 0);
    do_txn(1'b1, 32'hFFC, 2'd2, 1'b0, 32'h12345678, 0);
    do_txn(1'b0, 32'hFFC, 2'd2, 1'b0, 32'h0, 0);
    do_txn(1'b1, 32'hFFFFFFFF, 2'd3, 1'b0, 32'h55555555, 0);
    do_txn(1'b1, 32'hFFFFFFFE, 2'd1, 1'b0, 32'h0000AAAA, 0);
    do_txn(1'b1, 32'h201, 2'd1, 1'b0, 32'h0000A5A5, 0);
    check_val("ram_0x201", 32'(ram[12'h201]), 32'(ref_mem[12'h201]));
    check_val("ram_0x202", 32'(ram[12'h202]), 32'(ref_mem[12'h202]));
    do_txn(1'b0, 32'h201, 2'd0, 1'b1, 32'h0, 0);
    do_txn(1'b0, 32'h202, 2'd0, 1'b1, 32'h0, 0);

    // Load held 5 cycles, then a store accepted in the handoff cycle
    er = exp_load(32'h100, 2'd2, 1'b0);
    @(negedge clk);
    drive_req(1'b0, 32'h100, 2'd2, 1'b0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    bus.i_req_valid = 1'b0;
    @(negedge clk);
    #1;
    check_val("b2b_load_valid", 32'(bus.o_rsp_valid), 32'd1);
    for (int h = 0; h < 5; h++) begin
      @(negedge clk);
      #1;
      check_val("b2b_hold_valid", 32'(bus.o_rsp_valid), 32'd1);
      check_val("b2b_hold_rdata", bus.o_rsp_rdata, er);
      check_val("b2b_hold_ready", 32'(bus.o_req_ready), 32'd0);
    end
    drive_req(1'b1, 32'h300, 2'd2, 1'b0, 32'hCAFEF00D);
    bus.i_rsp_ready = 1'b1;
    #1;
    check_val("b2b_ready", 32'(bus.o_req_ready), 32'd1);
    check_val("b2b_mem_we", 32'(bus.o_mem_we), 32'd1);
    @(posedge clk);
    ref_store(32'h300, 2'd2, 32'hCAFEF00D);
    @(negedge clk);
    bus.i_req_valid = 1'b0;
    bus.i_rsp_ready = 1'b0;
    #1;
    check_val("b2b_st_valid", 32'(bus.o_rsp_valid), 32'd1);
    check_val("b2b_st_err", 32'(bus.o_rsp_err), 32'd0);
    check_val("b2b_st_rdata", bus.o_rsp_rdata, 32'd0);
    bus.i_rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.i_rsp_ready = 1'b0;
    #1;
    check_val("b2b_idle", 32'(bus.o_rsp_valid), 32'd0);
    do_txn(1'b0, 32'h300, 2'd2, 1'b0, 32'h0, 0);

    // Reset during RDWAIT aborts the load
    @(negedge clk);
    drive_req(1'b0, 32'h100, 2'd2, 1'b0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    bus.i_req_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check_val("rdw_rst_valid", 32'(bus.o_rsp_valid), 32'd0);
    check_val("rdw_rst_ready", 32'(bus.o_req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("rdw_rel_ready", 32'(bus.o_req_ready), 32'd1);
    @(negedge clk);
    #1;
    check_val("rdw_no_rsp", 32'(bus.o_rsp_valid), 32'd0);

    // Randomized transactions
    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      a = $urandom;
      else if (r == 1) a = 32'(DEPTH - $urandom_range(1, 6));
      else             a = 32'($urandom_range(0, 255));
      sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      do_txn(1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)), $urandom,
             $urandom_range(0, 2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
